// File: rtl/pc_controller.sv
// Program counter and instruction-fetch controller: a BOOT/FETCH/HOLD FSM that
// sequences fetch requests, applies trap/jump/branch redirects and counts completed fetches.
module pc_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap,
  input  logic        imem_ready,
  output logic [31:0] pc_out,
  output logic        imem_req,
  output logic        instr_valid,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  // Fetch handshake: imem_req is held high in FETCH for pc_out; the fetch
  // completes (instr_valid) in any cycle where imem_req and imem_ready are both high.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = 1'b0;
    imem_req    = (state_q == FETCH);
    instr_valid = imem_req & imem_ready;
    count_d     = count_q + {31'd0, instr_valid};

    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (trap) begin
          pc_d = TRAP_VECTOR;
        end else begin
          if (instr_valid) begin
            // A misaligned redirect target diverts to the trap vector instead.
            if (jump) begin
              if (jump_target[1:0] != 2'b00) begin
                pc_d       = TRAP_VECTOR;
                misalign_d = 1'b1;
              end else begin
                pc_d = jump_target;
              end
            end else if (branch_taken) begin
              if (branch_target[1:0] != 2'b00) begin
                pc_d       = TRAP_VECTOR;
                misalign_d = 1'b1;
              end else begin
                pc_d = branch_target;
              end
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
          if (stall) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (trap) begin
          pc_d    = TRAP_VECTOR;
          state_d = FETCH;
        end else if (!stall) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign pc_out      = pc_q;
  assign misalign    = misalign_q;
  assign fetch_count = count_q;

endmodule
